// File: rtl/ll_pkg.sv
// Shared definitions for singly_linked_list clients: op codes, walker FSM states
// and the address-width helper.
package ll_pkg;

    localparam logic [2:0] LL_OP_READ         = 3'd0;
    localparam logic [2:0] LL_OP_INSERT_ADDR  = 3'd1;
    localparam logic [2:0] LL_OP_DELETE_VALUE = 3'd2;
    localparam logic [2:0] LL_OP_DELETE_ADDR  = 3'd3;
    localparam logic [2:0] LL_OP_INSERT_INDEX = 3'd5;
    localparam logic [2:0] LL_OP_DELETE_INDEX = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StEmit,
        StFin
    } walker_state_e;

    // One extra code point is reserved for the null address.
    function automatic int unsigned ll_addr_width(input int unsigned max_node);
        return $clog2(max_node + 1);
    endfunction

endpackage

// File: rtl/ll_op_watchdog.sv
// Counts cycles spent waiting on a list op; flags expiry on the last allowed cycle.
// Only instantiated when LL_WALKER_TIMEOUT_EN is defined.
module ll_op_watchdog #(
    parameter int unsigned  TIMEOUT_CYCLES = 64,
    localparam int unsigned CntWidth       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic done_i,
    output logic expired_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && !done_i && (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || done_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/singly_linked_list_walker.sv
// Walks a singly_linked_list from head to tail with read ops and streams each node out.
// Optional op_done watchdog and sticky timeout output under LL_WALKER_TIMEOUT_EN.
module singly_linked_list_walker
    import ll_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH     = 8,
    parameter int unsigned  MAX_NODE       = 8,
    parameter int unsigned  TIMEOUT_CYCLES = 64,
    localparam int unsigned ADDR_WIDTH     = ll_addr_width(MAX_NODE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef LL_WALKER_TIMEOUT_EN
    output logic                  timeout,
`endif
    output logic [ADDR_WIDTH-1:0] node_cnt,
    output logic [2:0]            ll_op,
    output logic                  ll_op_start,
    output logic [ADDR_WIDTH-1:0] ll_addr_in,
    output logic [DATA_WIDTH-1:0] ll_data_in,
    input  logic                  ll_op_done,
    input  logic                  ll_fault,
    input  logic [DATA_WIDTH-1:0] ll_data_out,
    input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
    input  logic [ADDR_WIDTH-1:0] ll_head,
    input  logic [ADDR_WIDTH-1:0] ll_length,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(MAX_NODE);

    walker_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] node_cnt_q, node_cnt_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  err_q, err_d;
    logic                  abort_pend_q, abort_pend_d;
    logic                  op_start_q, op_start_d;
    logic                  last_c, early_err_c;
    logic                  wd_expired;

`ifdef LL_WALKER_TIMEOUT_EN
    logic timeout_q;

    ll_op_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (state_q == StWait),
        .done_i   (ll_op_done),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            timeout_q <= 1'b0;
        end else if (state_q == StWait && wd_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign wd_expired            = 1'b0;
`endif

    // A beat is final when the count is exhausted or the chain ends; disagreement is an error.
    assign last_c      = (cnt_q == len_q) || (nxt_q == ADDR_NULL);
    assign early_err_c = (nxt_q == ADDR_NULL) != (cnt_q == len_q);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        nxt_d        = nxt_q;
        addr_d       = addr_q;
        node_cnt_d   = node_cnt_q;
        m_addr_d     = m_addr_q;
        m_data_d     = m_data_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d        = ll_head;
                    len_d        = ll_length;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = (ll_length == '0) ? StFin : StIssue;
                end
            end
            StIssue: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    addr_d  = ptr_q;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (ll_op_done) begin
                    // An abort seen during the op drops the returned beat.
                    if (ll_fault || abort_pend_q || abort) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        m_data_d = ll_data_out;
                        m_addr_d = ptr_q;
                        nxt_d    = ll_next_node_addr;
                        cnt_d    = cnt_q + 1'b1;
                        state_d  = StEmit;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end
            end
            StEmit: begin
                if (m_ready) begin
                    if (last_c) begin
                        err_d   = early_err_c;
                        state_d = StFin;
                    end else if (abort) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        ptr_d   = nxt_q;
                        state_d = StIssue;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StFin) begin
            node_cnt_d = cnt_d;
        end
    end

    // Request is held exactly while waiting, so it drops the cycle after ll_op_done.
    assign op_start_d = (state_d == StWait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            nxt_q        <= '0;
            addr_q       <= ADDR_NULL;
            node_cnt_q   <= '0;
            m_addr_q     <= '0;
            m_data_q     <= '0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            op_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            nxt_q        <= nxt_d;
            addr_q       <= addr_d;
            node_cnt_q   <= node_cnt_d;
            m_addr_q     <= m_addr_d;
            m_data_q     <= m_data_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
            op_start_q   <= op_start_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StFin);
    assign err         = err_q;
    assign node_cnt    = node_cnt_q;
    assign ll_op       = LL_OP_READ;
    assign ll_op_start = op_start_q;
    assign ll_addr_in  = addr_q;
    assign ll_data_in  = '0;
    assign m_valid     = (state_q == StEmit);
    assign m_data      = m_data_q;
    assign m_addr      = m_addr_q;
    assign m_last      = (state_q == StEmit) && last_c;

endmodule
